// File: rtl/pos_cell_pingpong.sv
// rtl/pos_cell_pingpong.sv - double-buffered per-cell position memory
// Active bank serves reads; shadow bank takes appends; swap exchanges them.
module pos_cell_pingpong #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int INIT_COUNT   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_WORDS [(PARTICLE_NUM > 0) ? PARTICLE_NUM : 1] = '{default: '0}
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_in_range,
    output logic [ADDR_WIDTH-1:0] particle_count,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_overflow,
    input  logic                  swap,
    output logic                  active_bank
);

    localparam int MEM_DEPTH = (PARTICLE_NUM > 0) ? PARTICLE_NUM : 1;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] PN       = ADDR_WIDTH'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH-1:0] INIT_CNT = ADDR_WIDTH'(INIT_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    // Bank 0 powers up holding the cell image; bank 1 has no defined content.
    logic [DATA_WIDTH-1:0] bank0_mem [MEM_DEPTH] = INIT_WORDS;
    logic [DATA_WIDTH-1:0] bank1_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] cnt_q [2];
    logic [ADDR_WIDTH-1:0] cnt_d [2];
    logic                  active_bank_q, active_bank_d;
    logic                  wr_overflow_q, wr_overflow_d;

    logic                  rd_valid1_q, rd_valid1_d;
    logic                  sel1_q, sel1_d;
    logic                  hit1_q, hit1_d;
    logic [DATA_WIDTH-1:0] ram0_q, ram1_q;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_in_range_q, rd_in_range_d;

    logic                  shadow_sel;
    logic [ADDR_WIDTH-1:0] shadow_cnt;
    logic                  shadow_full;
    logic                  wr_accept;
    logic [MEM_AW-1:0]     wr_idx;
    logic [MEM_AW-1:0]     rd_idx;

    assign particle_count = cnt_q[active_bank_q];
    assign active_bank    = active_bank_q;
    assign wr_overflow    = wr_overflow_q;
    assign wr_full        = shadow_full;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign rd_in_range    = rd_in_range_q;

    always_comb begin
        shadow_sel  = ~active_bank_q;
        shadow_cnt  = cnt_q[shadow_sel];
        shadow_full = (shadow_cnt >= PN);
        wr_accept   = wr_en & ~shadow_full;
        wr_idx      = shadow_cnt[MEM_AW-1:0];
        rd_idx      = rd_addr[MEM_AW-1:0];

        cnt_d         = cnt_q;
        active_bank_d = active_bank_q;
        wr_overflow_d = wr_overflow_q;

        if (wr_accept) begin
            cnt_d[shadow_sel] = shadow_cnt + ONE;
        end
        if (wr_en && shadow_full) begin
            wr_overflow_d = 1'b1;
        end
        // Swap wins over any overflow raised in the same cycle.
        if (swap) begin
            active_bank_d        = ~active_bank_q;
            cnt_d[active_bank_q] = '0;
            wr_overflow_d        = 1'b0;
        end

        // Bank select and range are frozen at request time so a swap
        // landing behind an in-flight read cannot redirect it.
        rd_valid1_d = rd_en;
        sel1_d      = active_bank_q;
        hit1_d      = (rd_addr < particle_count);

        rd_valid_d    = rd_valid1_q;
        rd_in_range_d = hit1_q;
        rd_data_d     = hit1_q ? (sel1_q ? ram1_q : ram0_q) : '0;
    end

    always_ff @(posedge clock) begin
        if (wr_accept && !shadow_sel) begin
            bank0_mem[wr_idx] <= wr_data;
        end
        if (wr_accept && shadow_sel) begin
            bank1_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            ram0_q <= bank0_mem[rd_idx];
            ram1_q <= bank1_mem[rd_idx];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0]      <= INIT_CNT;
            cnt_q[1]      <= '0;
            active_bank_q <= 1'b0;
            wr_overflow_q <= 1'b0;
            rd_valid1_q   <= 1'b0;
            sel1_q        <= 1'b0;
            hit1_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_in_range_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            active_bank_q <= active_bank_d;
            wr_overflow_q <= wr_overflow_d;
            rd_valid1_q   <= rd_valid1_d;
            sel1_q        <= sel1_d;
            hit1_q        <= hit1_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_in_range_q <= rd_in_range_d;
        end
    end

endmodule

// File: tb/tb_pos_cell_pingpong.sv
// tb/tb_pos_cell_pingpong.sv - directed checks for pos_cell_pingpong
module tb_pos_cell_pingpong;

    localparam int DW = 96;
    localparam int PN = 4;
    localparam int AW = 3;
    localparam int IC = 3;
    localparam logic [DW-1:0] INIT_IMG [PN] = '{96'h111, 96'h222, 96'h333, 96'h444};

    logic          clock = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_in_range;
    logic [AW-1:0] particle_count;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic          wr_overflow;
    logic          swap = 1'b0;
    logic          active_bank;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          in_range;
    } rd_vec_t;

    rd_vec_t rvec [8];
    int n_checks = 0;
    int n_pass   = 0;

    pos_cell_pingpong #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW),
        .INIT_COUNT  (IC),
        .INIT_WORDS  (INIT_IMG)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_in_range   (rd_in_range),
        .particle_count(particle_count),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_overflow   (wr_overflow),
        .swap          (swap),
        .active_bank   (active_bank)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
        rvec[i].addr     = a;
        rvec[i].data     = d;
        rvec[i].in_range = r;
    endtask

    // Back-to-back reads of rvec[0..n-1]; each result appears two edges after issue.
    task automatic read_burst(input int n, input string tag);
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                chk($sformatf("%s_valid%0d", tag, i - 2), DW'(rd_valid), DW'(1));
                chk($sformatf("%s_data%0d", tag, i - 2), rd_data, rvec[i-2].data);
                chk($sformatf("%s_range%0d", tag, i - 2), DW'(rd_in_range), DW'(rvec[i-2].in_range));
            end else begin
                chk($sformatf("%s_lead_valid%0d", tag, i), DW'(rd_valid), DW'(0));
            end
            if (i < n) begin
                rd_en   = 1'b1;
                rd_addr = rvec[i].addr;
            end else begin
                rd_en = 1'b0;
            end
            step();
        end
        chk($sformatf("%s_tail_valid", tag), DW'(rd_valid), DW'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_rd_valid", DW'(rd_valid), DW'(0));
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_in_range", DW'(rd_in_range), DW'(0));
        chk("rst_count", DW'(particle_count), DW'(IC));
        chk("rst_active", DW'(active_bank), DW'(0));
        chk("rst_full", DW'(wr_full), DW'(0));
        chk("rst_overflow", DW'(wr_overflow), DW'(0));
        rst_n = 1'b1;
        step();

        // Init image: three counted words, word 3 exists in RAM but is beyond the count.
        set_vec(0, 3'd0, 96'h111, 1'b1);
        set_vec(1, 3'd1, 96'h222, 1'b1);
        set_vec(2, 3'd2, 96'h333, 1'b1);
        set_vec(3, 3'd3, 96'h0,   1'b0);
        set_vec(4, 3'd4, 96'h0,   1'b0);
        read_burst(5, "init");

        do_write(96'hA);
        do_write(96'hB);
        do_write(96'hC);
        chk("pre_swap_count", DW'(particle_count), DW'(3));
        chk("pre_swap_full", DW'(wr_full), DW'(0));
        do_swap();
        chk("swap1_count", DW'(particle_count), DW'(3));
        chk("swap1_active", DW'(active_bank), DW'(1));
        chk("swap1_full", DW'(wr_full), DW'(0));
        set_vec(0, 3'd0, 96'hA, 1'b1);
        set_vec(1, 3'd1, 96'hB, 1'b1);
        set_vec(2, 3'd2, 96'hC, 1'b1);
        set_vec(3, 3'd3, 96'h0, 1'b0);
        read_burst(4, "abc");

        for (int i = 1; i <= 5; i++) begin
            do_write(DW'(8'h50 + i));
            chk($sformatf("ovf_full_w%0d", i), DW'(wr_full), DW'(i >= 4));
            chk($sformatf("ovf_flag_w%0d", i), DW'(wr_overflow), DW'(i >= 5));
        end
        do_swap();
        chk("swap2_count", DW'(particle_count), DW'(4));
        chk("swap2_active", DW'(active_bank), DW'(0));
        chk("swap2_overflow", DW'(wr_overflow), DW'(0));
        chk("swap2_full", DW'(wr_full), DW'(0));
        set_vec(0, 3'd0, 96'h51, 1'b1);
        set_vec(1, 3'd1, 96'h52, 1'b1);
        set_vec(2, 3'd2, 96'h53, 1'b1);
        set_vec(3, 3'd3, 96'h54, 1'b1);
        set_vec(4, 3'd4, 96'h0,  1'b0);
        read_burst(5, "full");

        // Write coinciding with swap is counted into the bank being promoted.
        do_write(96'h61);
        do_write(96'h62);
        wr_en   = 1'b1;
        wr_data = 96'hD;
        swap    = 1'b1;
        step();
        wr_en = 1'b0;
        swap  = 1'b0;
        chk("wrswap_count", DW'(particle_count), DW'(3));
        chk("wrswap_active", DW'(active_bank), DW'(1));
        set_vec(0, 3'd0, 96'h61, 1'b1);
        set_vec(1, 3'd1, 96'h62, 1'b1);
        set_vec(2, 3'd2, 96'hD,  1'b1);
        read_burst(3, "wrswap");

        // Read coinciding with swap is served from the outgoing bank.
        do_write(96'h71);
        rd_en   = 1'b1;
        rd_addr = 3'd0;
        swap    = 1'b1;
        step();
        rd_en = 1'b0;
        swap  = 1'b0;
        chk("rdswap_active", DW'(active_bank), DW'(0));
        chk("rdswap_count", DW'(particle_count), DW'(1));
        step();
        chk("rdswap_valid", DW'(rd_valid), DW'(1));
        chk("rdswap_data", rd_data, 96'h61);
        chk("rdswap_range", DW'(rd_in_range), DW'(1));

        // Reset with two reads in flight.
        rd_en   = 1'b1;
        rd_addr = 3'd0;
        step();
        rd_addr = 3'd1;
        step();
        rd_en = 1'b0;
        chk("inflight_valid_pre", DW'(rd_valid), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("inflight_valid_async", DW'(rd_valid), DW'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_valid", DW'(rd_valid), DW'(0));
        chk("rst2_count", DW'(particle_count), DW'(IC));
        chk("rst2_active", DW'(active_bank), DW'(0));
        chk("rst2_overflow", DW'(wr_overflow), DW'(0));
        chk("rst2_full", DW'(wr_full), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
